decouple_skid_buffer: RTL
=========================

# decouple_skid_buffer

Two-entry valid/ready skid buffer that registers both directions of the handshake: `out_valid`/`out_data` forward and `in_ready` backward. It sits between floating-point pipeline stages wherever the combinational `out_ready` → `in_ready` path of a plain pipeline-register controller would otherwise span several stages and limit timing. It sustains one transfer per cycle, preserves order, and never drops or duplicates a beat except on an explicit flush.

## Interface
- `DATA_WIDTH`, default 32: width of the payload carried with each beat.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous discard of all buffered beats; highest priority.
- `in_valid`  in  1  upstream beat valid.
- `in_data`  in  DATA_WIDTH  upstream payload.
- `in_ready`  out  1  registered; buffer can accept a beat this cycle.
- `out_valid`  out  1  registered; `out_data` holds a valid beat.
- `out_data`  out  DATA_WIDTH  registered payload of the oldest beat.
- `out_ready`  in  1  downstream accepts the beat this cycle.
- `occupancy`  out  2  number of beats held (0, 1 or 2).

## Operation
- Storage: the output register `out_data` plus one skid register `skid_data`.
- Handshake events: `in_fire = in_valid & in_ready` and `out_fire = out_valid & out_ready`.
- States:
  - EMPTY (occupancy 0): `out_valid`=0, `in_ready`=1.
  - BUSY (occupancy 1): `out_valid`=1, `in_ready`=1.
  - FULL (occupancy 2): `out_valid`=1, `in_ready`=0.
- `in_ready`, `out_valid` and `occupancy` are flops decoded from the next state. No combinational path exists from `out_ready` to `in_ready` or from `in_valid` to `out_valid`.
- Transitions when `flush`=0:
  - EMPTY, `in_fire`: go to BUSY and load `out_data`←`in_data`.
  - BUSY, `in_fire` & !`out_fire`: go to FULL and load `skid_data`←`in_data`.
  - BUSY, `in_fire` & `out_fire`: stay in BUSY and load `out_data`←`in_data`.
  - BUSY, !`in_fire` & `out_fire`: go to EMPTY.
  - FULL, `out_fire`: go to BUSY and load `out_data`←`skid_data`. No `in_fire` is possible because `in_ready`=0.
  - Any other combination: hold state and data.
- Flush:
  - `flush`=1 forces EMPTY on the next edge, whatever `in_fire` or `out_fire` occur in the same cycle.
  - A beat offered with `in_fire` in the flush cycle is discarded.
  - A beat that completes `out_fire` in the flush cycle counts as delivered.
  - Data registers keep their contents; only the state changes.
- `out_data` is stable while `out_valid`=1 and `out_ready`=0; it changes only on `out_fire` or on entry from EMPTY.
- Beats leave in the order they were accepted.

## Timing
- Reset values: state EMPTY, `in_ready`=1, `out_valid`=0, `occupancy`=0, `out_data`=0, `skid_data`=0.
- Reset is asynchronous. Asserting it mid-operation drops every buffered beat immediately. The first `in_fire` is possible in the first cycle after reset deasserts.
- Latency: a beat accepted on edge N is presented with `out_valid`=1 after edge N (one cycle) when the buffer was EMPTY. When the buffer was not empty, the beat waits behind the older beats.
- Throughput: with `in_valid`=`out_ready`=1 continuously, the buffer stays in BUSY and carries one beat per cycle.
- Back-pressure: when `out_ready` drops while the buffer is BUSY and a new beat arrives, the new beat lands in the skid register. `in_ready` falls on the following edge, so `in_ready` reacts to `out_ready` exactly one cycle late.
- Recovery: the first `out_fire` in FULL raises `in_ready` on the next edge.
- Simultaneous fire in BUSY is replace-in-place with no bubble. Simultaneous `flush` and `reset`: `reset` wins.

## Test plan
- Reset, then hold `in_valid`=0: the bench observes `in_ready`=1, `out_valid`=0, `occupancy`=0 and `out_data`=0 until the first beat.
- Streaming: send 0x1,0x2,…,0x10 on consecutive cycles with `out_ready`=1. Required: the outputs arrive in the same order one cycle after acceptance, one per cycle, `occupancy` stays 1 and `in_ready` stays 1.
- Stall: with `out_ready`=0, offer 0xA then 0xB. Required: `occupancy` goes to 2, `in_ready`=0 from the next cycle and 0xC is held off. Then raise `out_ready`; the outputs must be 0xA, 0xB, 0xC with no loss or duplication.
- Random: randomize `in_valid` and `out_ready` (50%) over 10k beats with incrementing data. A scoreboard must match in order, `out_data` must stay stable whenever `out_valid` & !`out_ready`, and `in_ready` must never depend on same-cycle `out_ready`.
- Flush in FULL with `in_valid`=1 and `out_ready`=1 (holding 0x5 and 0x6, offering 0x7): 0x5 is delivered and 0x6 and 0x7 are discarded. The next cycle must show EMPTY with `in_ready`=1 and `out_valid`=0.
- Assert `reset` asynchronously while the buffer is FULL, mid-cycle: `out_valid`=0, `in_ready`=1 and `occupancy`=0 immediately, with no beat emitted after deassertion.

Source files
------------

// File: rtl/decouple_skid_buffer.sv
// Two-entry valid/ready skid buffer. Both directions of the handshake come
// straight from flops, so out_ready never reaches in_ready combinationally.
module decouple_skid_buffer #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   input  logic                  out_ready,
   output logic [1:0]            occupancy
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic                  r_in_ready;
   logic                  r_out_valid;
   logic [1:0]            r_occupancy;
   logic [DATA_WIDTH-1:0] r_out_data;
   logic [DATA_WIDTH-1:0] r_skid_data;

   logic                  w_in_fire;
   logic                  w_out_fire;
   logic                  w_load_out_from_in;
   logic                  w_load_out_from_skid;
   logic                  w_load_skid;
   logic                  w_in_ready_next;
   logic                  w_out_valid_next;
   logic [1:0]            w_occupancy_next;

   assign w_in_fire  = in_valid & r_in_ready;
   assign w_out_fire = r_out_valid & out_ready;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of the order the always blocks are evaluated.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= EMPTY;
      else       r_state <= w_state_next;
   end

   // NOTE: every signal gets a default before the case so no latch is inferred
   // for combinations the case does not mention.
   always_comb begin
      w_state_next         = r_state;
      w_load_out_from_in   = 1'b0;
      w_load_out_from_skid = 1'b0;
      w_load_skid          = 1'b0;
      if (flush) begin
         // Data registers keep their contents; only the state is discarded.
         w_state_next = EMPTY;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_in_fire) begin
                  w_state_next       = BUSY;
                  w_load_out_from_in = 1'b1;
               end
            end
            BUSY: begin
               if (w_in_fire && !w_out_fire) begin
                  w_state_next = FULL;
                  w_load_skid  = 1'b1;
               end else if (w_in_fire && w_out_fire) begin
                  w_load_out_from_in = 1'b1;
               end else if (w_out_fire) begin
                  w_state_next = EMPTY;
               end
            end
            FULL: begin
               if (w_out_fire) begin
                  w_state_next         = BUSY;
                  w_load_out_from_skid = 1'b1;
               end
            end
            default: w_state_next = EMPTY;
         endcase
      end
   end

   // Handshake outputs are decoded from the next state and then registered.
   always_comb begin
      w_in_ready_next  = 1'b1;
      w_out_valid_next = 1'b0;
      w_occupancy_next = 2'd0;
      case (w_state_next)
         BUSY: begin
            w_out_valid_next = 1'b1;
            w_occupancy_next = 2'd1;
         end
         FULL: begin
            w_in_ready_next  = 1'b0;
            w_out_valid_next = 1'b1;
            w_occupancy_next = 2'd2;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_occupancy <= 2'd0;
      end else begin
         r_in_ready  <= w_in_ready_next;
         r_out_valid <= w_out_valid_next;
         r_occupancy <= w_occupancy_next;
      end
   end

   // NOTE: the payload registers are reset too, so out_data reads 0 before the
   // first beat instead of an undefined value.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_out_data  <= '0;
         r_skid_data <= '0;
      end else begin
         if (w_load_out_from_in)        r_out_data <= in_data;
         else if (w_load_out_from_skid) r_out_data <= r_skid_data;
         if (w_load_skid)               r_skid_data <= in_data;
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign occupancy = r_occupancy;

endmodule
